// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, one-hot control bit positions
// and bus widths used by the ALU initiator logic.
package alu_pkg;

    localparam int ALU_CTRL_W = 12;
    localparam int ALU_DATA_W = 64;

    localparam logic [3:0] ALU_OP_ADD  = 4'd0;
    localparam logic [3:0] ALU_OP_SUB  = 4'd1;
    localparam logic [3:0] ALU_OP_SLT  = 4'd2;
    localparam logic [3:0] ALU_OP_SLTU = 4'd3;
    localparam logic [3:0] ALU_OP_AND  = 4'd4;
    localparam logic [3:0] ALU_OP_NOR  = 4'd5;
    localparam logic [3:0] ALU_OP_OR   = 4'd6;
    localparam logic [3:0] ALU_OP_XOR  = 4'd7;
    localparam logic [3:0] ALU_OP_SLL  = 4'd8;
    localparam logic [3:0] ALU_OP_SRL  = 4'd9;
    localparam logic [3:0] ALU_OP_SRA  = 4'd10;
    localparam logic [3:0] ALU_OP_LUI  = 4'd11;

    localparam int ALU_ADD_BIT  = 11;
    localparam int ALU_SUB_BIT  = 10;
    localparam int ALU_SLT_BIT  = 9;
    localparam int ALU_SLTU_BIT = 8;
    localparam int ALU_AND_BIT  = 7;
    localparam int ALU_NOR_BIT  = 6;
    localparam int ALU_OR_BIT   = 5;
    localparam int ALU_XOR_BIT  = 4;
    localparam int ALU_SLL_BIT  = 3;
    localparam int ALU_SRL_BIT  = 2;
    localparam int ALU_SRA_BIT  = 1;
    localparam int ALU_LUI_BIT  = 0;

    typedef logic [ALU_CTRL_W-1:0] alu_ctrl_t;
    typedef logic [ALU_DATA_W-1:0] alu_data_t;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational opcode decoder: 4-bit opcode to the ALU one-hot control bus.
// Illegal opcodes produce an all-zero control word with legal deasserted.
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [3:0] op,
    output alu_ctrl_t  ctrl,
    output logic       legal
);

    always_comb begin
        ctrl  = '0;
        legal = 1'b1;
        case (op)
            ALU_OP_ADD:  ctrl[ALU_ADD_BIT]  = 1'b1;
            ALU_OP_SUB:  ctrl[ALU_SUB_BIT]  = 1'b1;
            ALU_OP_SLT:  ctrl[ALU_SLT_BIT]  = 1'b1;
            ALU_OP_SLTU: ctrl[ALU_SLTU_BIT] = 1'b1;
            ALU_OP_AND:  ctrl[ALU_AND_BIT]  = 1'b1;
            ALU_OP_NOR:  ctrl[ALU_NOR_BIT]  = 1'b1;
            ALU_OP_OR:   ctrl[ALU_OR_BIT]   = 1'b1;
            ALU_OP_XOR:  ctrl[ALU_XOR_BIT]  = 1'b1;
            ALU_OP_SLL:  ctrl[ALU_SLL_BIT]  = 1'b1;
            ALU_OP_SRL:  ctrl[ALU_SRL_BIT]  = 1'b1;
            ALU_OP_SRA:  ctrl[ALU_SRA_BIT]  = 1'b1;
            ALU_OP_LUI:  ctrl[ALU_LUI_BIT]  = 1'b1;
            default:     legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_issue.sv
// Two-stage issue/response sequencer in front of the combinational ALU:
// S1 drives the ALU, S2 captures its result and returns it in order.
module alu_issue
    import alu_pkg::*;
#(
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_op,
    input  alu_data_t        req_src1,
    input  alu_data_t        req_src2,
    input  logic [TAG_W-1:0] req_tag,
    output alu_ctrl_t        alu_control,
    output alu_data_t        alu_src1,
    output alu_data_t        alu_src2,
    input  alu_data_t        alu_result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output alu_data_t        rsp_result,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_err,
    output logic [31:0]      issue_count,
    output logic [15:0]      err_count
);

    alu_ctrl_t        dec_ctrl;
    logic             dec_legal;

    logic             s1_valid;
    alu_ctrl_t        s1_ctrl;
    alu_data_t        s1_src1;
    alu_data_t        s1_src2;
    logic [TAG_W-1:0] s1_tag;
    logic             s1_err;

    logic             s2_valid;
    alu_data_t        s2_result;
    logic [TAG_W-1:0] s2_tag;
    logic             s2_err;

    logic             req_fire;
    logic             s2_load;

    alu_op_decode u_decode (
        .op    (req_op),
        .ctrl  (dec_ctrl),
        .legal (dec_legal)
    );

    // S2 frees up in the same edge it hands its entry off, so S1 can move on.
    assign s2_load   = s1_valid && (!s2_valid || rsp_ready);
    assign req_ready = !s1_valid || !s2_valid || rsp_ready;
    assign req_fire  = req_valid && req_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_ctrl  <= '0;
            s1_src1  <= '0;
            s1_src2  <= '0;
            s1_tag   <= '0;
            s1_err   <= 1'b0;
        end else if (req_fire) begin
            s1_valid <= 1'b1;
            s1_ctrl  <= dec_ctrl;
            s1_src1  <= req_src1;
            s1_src2  <= req_src2;
            s1_tag   <= req_tag;
            s1_err   <= !dec_legal;
        end else if (s2_load) begin
            s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2_valid  <= 1'b0;
            s2_result <= '0;
            s2_tag    <= '0;
            s2_err    <= 1'b0;
        end else if (s2_load) begin
            s2_valid  <= 1'b1;
            s2_result <= s1_err ? '0 : alu_result;
            s2_tag    <= s1_tag;
            s2_err    <= s1_err;
        end else if (s2_valid && rsp_ready) begin
            s2_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            issue_count <= '0;
            err_count   <= '0;
        end else if (req_fire) begin
            issue_count <= issue_count + 32'd1;
            if (!dec_legal && err_count != 16'hFFFF) begin
                err_count <= err_count + 16'd1;
            end
        end
    end

    // Idle ALU inputs are forced to zero so the bus is quiet between ops.
    assign alu_control = s1_valid ? s1_ctrl : '0;
    assign alu_src1    = s1_valid ? s1_src1 : '0;
    assign alu_src2    = s1_valid ? s1_src2 : '0;

    assign rsp_valid  = s2_valid;
    assign rsp_result = s2_result;
    assign rsp_tag    = s2_tag;
    assign rsp_err    = s2_err;

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue; the bench also plays the role of the ALU.
module tb_alu_issue;

    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [3:0]       req_op = '0;
    logic [63:0]      req_src1 = '0;
    logic [63:0]      req_src2 = '0;
    logic [TAG_W-1:0] req_tag = '0;
    logic [11:0]      alu_control;
    logic [63:0]      alu_src1;
    logic [63:0]      alu_src2;
    logic [63:0]      alu_result;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic [63:0]      rsp_result;
    logic [TAG_W-1:0] rsp_tag;
    logic             rsp_err;
    logic [31:0]      issue_count;
    logic [15:0]      err_count;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    alu_issue #(.TAG_W(TAG_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_src1    (req_src1),
        .req_src2    (req_src2),
        .req_tag     (req_tag),
        .alu_control (alu_control),
        .alu_src1    (alu_src1),
        .alu_src2    (alu_src2),
        .alu_result  (alu_result),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_result  (rsp_result),
        .rsp_tag     (rsp_tag),
        .rsp_err     (rsp_err),
        .issue_count (issue_count),
        .err_count   (err_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Combinational ALU stand-in; a zero or multi-hot control yields junk.
    function automatic logic [63:0] alu_model(logic [11:0] c, logic [63:0] a, logic [63:0] b);
        case (c)
            12'h800: return a + b;
            12'h400: return a - b;
            12'h200: return {63'd0, $signed(a) < $signed(b)};
            12'h100: return {63'd0, a < b};
            12'h080: return a & b;
            12'h040: return ~(a | b);
            12'h020: return a | b;
            12'h010: return a ^ b;
            12'h008: return a << b[5:0];
            12'h004: return a >> b[5:0];
            12'h002: return $signed(a) >>> b[5:0];
            12'h001: return b << 16;
            default: return 64'hDEAD_BEEF_0BAD_F00D;
        endcase
    endfunction

    always_comb alu_result = alu_model(alu_control, alu_src1, alu_src2);

    // Expected response from the opcode itself.
    function automatic logic [63:0] ref_result(logic [3:0] op, logic [63:0] a, logic [63:0] b);
        logic signed [63:0] sa;
        sa = a;
        case (op)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return (sa < $signed(b)) ? 64'd1 : 64'd0;
            4'd3:  return (a < b) ? 64'd1 : 64'd0;
            4'd4:  return a & b;
            4'd5:  return ~(a | b);
            4'd6:  return a | b;
            4'd7:  return a ^ b;
            4'd8:  return a << b[5:0];
            4'd9:  return a >> b[5:0];
            4'd10: return sa >>> b[5:0];
            4'd11: return b << 16;
            default: return 64'd0;
        endcase
    endfunction

    function automatic logic [63:0] rand64();
        return {$urandom, $urandom};
    endfunction

    task automatic do_reset();
        @(posedge clk);
        #1 reset = 1'b1;
        req_valid = 1'b0;
        #2 reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Presents a request and returns one step after the accepting edge.
    task automatic send(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                        input logic [TAG_W-1:0] t, output bit ok);
        bit hit;
        ok = 1'b0;
        req_valid = 1'b1;
        req_op    = op;
        req_src1  = a;
        req_src2  = b;
        req_tag   = t;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            hit = req_ready;
            @(posedge clk);
            #1;
            if (hit) begin
                ok = 1'b1;
                break;
            end
        end
        req_valid = 1'b0;
    endtask

    task automatic get_rsp(output logic [63:0] r, output logic [TAG_W-1:0] t, output logic e,
                           output bit ok);
        bit hit;
        ok = 1'b0;
        r  = '0;
        t  = '0;
        e  = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            hit = rsp_valid && rsp_ready;
            if (hit) begin
                r = rsp_result;
                t = rsp_tag;
                e = rsp_err;
            end
            @(posedge clk);
            #1;
            if (hit) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1;
        total++;
        if (rsp_valid !== 1'b0 || alu_control !== 12'h000 || rsp_result !== 64'd0) begin
            bad++;
            $display("FAIL reset_outputs: rsp_valid=%b alu_control=%h rsp_result=%h required 0/000/0",
                     rsp_valid, alu_control, rsp_result);
        end
        reset = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (req_ready !== 1'b1 || issue_count !== 32'd0 || err_count !== 16'd0 ||
            alu_src1 !== 64'd0 || rsp_tag !== '0 || rsp_err !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle: req_ready=%b issue=%0d err=%0d src1=%h tag=%h rsp_err=%b required 1/0/0/0/0/0",
                     req_ready, issue_count, err_count, alu_src1, rsp_tag, rsp_err);
        end
    endtask

    task automatic test_add();
        bit ok;
        do_reset();
        rsp_ready = 1'b1;
        send(4'd0, 64'd5, 64'd7, 4'd3, ok);
        total++;
        if (!ok || alu_control !== 12'h800 || alu_src1 !== 64'd5 || alu_src2 !== 64'd7 || rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL add_issue: ok=%b ctrl=%h src1=%0d src2=%0d rsp_valid=%b required 1/800/5/7/0",
                     ok, alu_control, alu_src1, alu_src2, rsp_valid);
        end
        @(posedge clk);
        #1;
        total++;
        if (rsp_valid !== 1'b1 || rsp_result !== 64'd12 || rsp_tag !== 4'd3 || rsp_err !== 1'b0) begin
            bad++;
            $display("FAIL add_rsp: valid=%b result=%0d tag=%0d err=%b required 1/12/3/0",
                     rsp_valid, rsp_result, rsp_tag, rsp_err);
        end
        @(posedge clk);
        #1;
        total++;
        if (rsp_valid !== 1'b0 || alu_control !== 12'h000) begin
            bad++;
            $display("FAIL add_drain: rsp_valid=%b ctrl=%h required 0/000", rsp_valid, alu_control);
        end
    endtask

    task automatic test_sub_wrap();
        bit ok;
        send(4'd1, 64'd0, 64'd1, 4'd5, ok);
        total++;
        if (!ok || alu_control !== 12'h400) begin
            bad++;
            $display("FAIL sub_issue: ok=%b ctrl=%h required 1/400", ok, alu_control);
        end
        @(posedge clk);
        #1;
        total++;
        if (rsp_valid !== 1'b1 || rsp_result !== 64'hFFFF_FFFF_FFFF_FFFF || rsp_tag !== 4'd5) begin
            bad++;
            $display("FAIL sub_wrap: valid=%b result=%h tag=%0d required 1/ffffffffffffffff/5",
                     rsp_valid, rsp_result, rsp_tag);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_backpressure();
        logic [3:0]  ops[4];
        logic [63:0] as[4];
        logic [63:0] bs[4];
        logic [11:0] held;
        logic [63:0] r;
        logic [TAG_W-1:0] t;
        logic e;
        bit ok2, ok3, okr;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            ops[i] = 4'($urandom_range(0, 11));
            as[i]  = rand64();
            bs[i]  = rand64();
        end
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_op = ops[0]; req_src1 = as[0]; req_src2 = bs[0]; req_tag = 4'd0;
        @(posedge clk);
        #1;
        req_op = ops[1]; req_src1 = as[1]; req_src2 = bs[1]; req_tag = 4'd1;
        total++;
        if (req_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp_second_ready: req_ready=%b required 1", req_ready);
        end
        @(posedge clk);
        #1;
        req_op = ops[2]; req_src1 = as[2]; req_src2 = bs[2]; req_tag = 4'd2;
        held = alu_control;
        total++;
        if (req_ready !== 1'b0 || held !== (12'h800 >> ops[1])) begin
            bad++;
            $display("FAIL bp_full: req_ready=%b ctrl=%h required 0/%h", req_ready, held, 12'h800 >> ops[1]);
        end
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (req_ready !== 1'b0 || alu_control !== held || alu_src1 !== as[1] || issue_count !== 32'd2 ||
            rsp_valid !== 1'b1 || rsp_tag !== 4'd0 || rsp_result !== ref_result(ops[0], as[0], bs[0])) begin
            bad++;
            $display("FAIL bp_hold: req_ready=%b ctrl=%h issue=%0d rsp_valid=%b tag=%0d result=%h required 0/%h/2/1/0/%h",
                     req_ready, alu_control, issue_count, rsp_valid, rsp_tag, rsp_result, held,
                     ref_result(ops[0], as[0], bs[0]));
        end
        rsp_ready = 1'b1;
        fork
            begin
                send(ops[2], as[2], bs[2], 4'd2, ok2);
                send(ops[3], as[3], bs[3], 4'd3, ok3);
            end
            begin
                for (int i = 0; i < 4; i++) begin
                    get_rsp(r, t, e, okr);
                    total++;
                    if (!okr || t !== 4'(i) || e !== 1'b0 || r !== ref_result(ops[i], as[i], bs[i])) begin
                        bad++;
                        $display("FAIL bp_order[%0d]: got=%b tag=%0d err=%b result=%h required tag=%0d result=%h",
                                 i, okr, t, e, r, i, ref_result(ops[i], as[i], bs[i]));
                    end
                end
            end
        join
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (!ok2 || !ok3 || rsp_valid !== 1'b0 || issue_count !== 32'd4) begin
            bad++;
            $display("FAIL bp_after: sent2=%b sent3=%b rsp_valid=%b issue=%0d required 1/1/0/4",
                     ok2, ok3, rsp_valid, issue_count);
        end
    endtask

    task automatic test_illegal();
        bit ok;
        do_reset();
        rsp_ready = 1'b1;
        send(4'd13, 64'hFF, 64'hFF, 4'd9, ok);
        total++;
        if (!ok || alu_control !== 12'h000 || err_count !== 16'd1 || issue_count !== 32'd1) begin
            bad++;
            $display("FAIL illegal_issue: ok=%b ctrl=%h err_count=%0d issue=%0d required 1/000/1/1",
                     ok, alu_control, err_count, issue_count);
        end
        @(posedge clk);
        #1;
        total++;
        if (rsp_valid !== 1'b1 || rsp_result !== 64'd0 || rsp_err !== 1'b1 || rsp_tag !== 4'd9) begin
            bad++;
            $display("FAIL illegal_rsp: valid=%b result=%h err=%b tag=%0d required 1/0/1/9",
                     rsp_valid, rsp_result, rsp_err, rsp_tag);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_midflight();
        bit ok;
        bit seen;
        do_reset();
        rsp_ready = 1'b0;
        send(4'd0, 64'd1, 64'd2, 4'd1, ok);
        send(4'd7, 64'd3, 64'd4, 4'd2, ok);
        total++;
        if (rsp_valid !== 1'b1 || alu_control !== 12'h010 || req_ready !== 1'b0) begin
            bad++;
            $display("FAIL midflight_pre: rsp_valid=%b ctrl=%h req_ready=%b required 1/010/0",
                     rsp_valid, alu_control, req_ready);
        end
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        total++;
        if (rsp_valid !== 1'b0 || alu_control !== 12'h000 || issue_count !== 32'd0 ||
            err_count !== 16'd0 || req_ready !== 1'b1) begin
            bad++;
            $display("FAIL midflight_reset: rsp_valid=%b ctrl=%h issue=%0d err=%0d req_ready=%b required 0/000/0/0/1",
                     rsp_valid, alu_control, issue_count, err_count, req_ready);
        end
        #1 reset = 1'b0;
        rsp_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        total++;
        if (seen) begin
            bad++;
            $display("FAIL midflight_stale: stale response seen=%b required 0", seen);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_throughput();
        localparam int N = 100;
        logic [3:0]  ops[N];
        logic [63:0] as[N];
        logic [63:0] bs[N];
        int start_cyc, end_cyc, nbad, ngot;
        bit all_sent;
        do_reset();
        for (int i = 0; i < N; i++) begin
            ops[i] = 4'($urandom_range(0, 11));
            as[i]  = rand64();
            bs[i]  = rand64();
        end
        rsp_ready = 1'b1;
        nbad = 0;
        ngot = 0;
        all_sent = 1'b1;
        start_cyc = cyc;
        fork
            begin
                bit ok;
                for (int i = 0; i < N; i++) begin
                    send(ops[i], as[i], bs[i], 4'(i), ok);
                    if (!ok) all_sent = 1'b0;
                end
            end
            begin
                logic [63:0] r;
                logic [TAG_W-1:0] t;
                logic e;
                bit okr;
                for (int i = 0; i < N; i++) begin
                    get_rsp(r, t, e, okr);
                    if (okr) ngot++;
                    if (!okr || t !== 4'(i) || e !== 1'b0 || r !== ref_result(ops[i], as[i], bs[i])) begin
                        nbad++;
                        if (nbad <= 5)
                            $display("FAIL tp_rsp[%0d]: got=%b tag=%0d result=%h required tag=%0d result=%h",
                                     i, okr, t, r, i % 16, ref_result(ops[i], as[i], bs[i]));
                    end
                end
                end_cyc = cyc;
            end
        join
        total++;
        if (nbad != 0 || ngot != N || !all_sent) begin
            bad++;
            $display("FAIL tp_results: mismatched=%0d received=%0d all_sent=%b required 0/%0d/1",
                     nbad, ngot, all_sent, N);
        end
        total++;
        if (end_cyc - start_cyc > 102) begin
            bad++;
            $display("FAIL tp_cycles: cycles=%0d required <=102", end_cyc - start_cyc);
        end
        total++;
        if (issue_count !== 32'd100) begin
            bad++;
            $display("FAIL tp_issue_count: issue_count=%0d required 100", issue_count);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_wrap();
        test_backpressure();
        test_illegal();
        test_reset_midflight();
        test_throughput();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_issue.md
# alu_issue

Pipelined issue/response sequencer that sits in front of the combinational 64-bit `alu`. It accepts tagged operation requests over a valid/ready handshake and encodes the opcode into the one-hot `alu_control` bus. It drives the operands, captures `alu_result` one cycle later and returns it in order over a second valid/ready handshake. It is the initiator side of the ALU interface and replaces free-running stimulus with a flow-controlled producer and consumer.

## Interface
- `TAG_W`, default 4: request/response tag width.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `req_valid` input 1: request present.
- `req_ready` output 1: request accepted when `req_valid && req_ready` at a rising edge.
- `req_op` input 4: encoded opcode 0–11 (see Operation); 12–15 illegal.
- `req_src1`, `req_src2` input 64: operands.
- `req_tag` input `TAG_W`: returned unchanged with the result.
- `alu_control` output 12: one-hot to ALU.
- `alu_src1`, `alu_src2` output 64: operands to ALU.
- `alu_result` input 64: ALU combinational result.
- `rsp_valid` output 1: response present.
- `rsp_ready` input 1: response consumed when `rsp_valid && rsp_ready` at a rising edge.
- `rsp_result` output 64, `rsp_tag` output `TAG_W`, `rsp_err` output 1: illegal opcode flag.
- `issue_count` output 32: accepted requests, wraps modulo 2^32.
- `err_count` output 16: illegal requests, saturates at 0xFFFF.

## Operation
- Opcode to `alu_control` bit: 0 add→bit11, 1 sub→10, 2 slt→9, 3 sltu→8, 4 and→7, 5 nor→6, 6 or→5, 7 xor→4, 8 sll→3, 9 srl→2, 10 sra→1, 11 lui→0.
- Two pipeline stages:
  - S1 holds op one-hot, operands, tag and err. It drives the ALU.
  - S2 holds result, tag and err. It drives the `rsp_*` outputs.
- `rsp_valid` = S2 valid.
- S2 loads from S1 when S1 is valid and (S2 empty or S2 handshaking this edge).
- S1 loads on request handshake.
- `req_ready` = !S1.valid || !S2.valid || rsp_ready. This is combinational and gives a full-throughput bubble-free pipe.
- S1 empty: `alu_control`, `alu_src1` and `alu_src2` are driven 0.
- Illegal opcode:
  - S1 stores `alu_control` = 0 and err = 1.
  - S2 stores result 0 regardless of `alu_result`.
  - `err_count` increments on acceptance.
- Responses leave strictly in acceptance order; none are dropped or duplicated.
- `rsp_*` data is stable while `rsp_valid && !rsp_ready`.
- All arithmetic is performed in the ALU; this block adds no width conversion.
- Both counters update at the request handshake edge only.

## Timing
- Reset values, applied immediately on `reset` assertion:
  - S1 and S2 invalid.
  - `rsp_valid` 0; `rsp_result`, `rsp_tag`, `rsp_err` 0.
  - `alu_control`, `alu_src1`, `alu_src2` 0.
  - Both counters 0.
  - `req_ready` = 1 after reset, since it is a function of the empty pipe.
- Latency: request accepted at edge E, `alu_control` valid in the cycle after E, `rsp_valid` high after edge E+1. The response is therefore visible two cycles after the request cycle.
- Throughput: 1 op/cycle while `rsp_ready` stays high.
- Both stages full and `rsp_ready` = 0: `req_ready` = 0 and S1 holds. ALU inputs stay stable, so `alu_result` remains valid for the late S2 load.
- Simultaneous response handshake and request handshake in the same edge: S2 takes S1 and S1 takes the new request, with no bubble.
- Reset asserted mid-operation: in-flight entries are discarded, no response is emitted for them, and counters clear.

## Structure
- Shared package `alu_pkg` contains:
  - opcode localparams `ALU_OP_ADD`…`ALU_OP_LUI`;
  - one-hot bit index constants `ALU_ADD_BIT`=11…`ALU_LUI_BIT`=0;
  - `ALU_CTRL_W`=12 and `ALU_DATA_W`=64.
- One sub-module, `alu_op_decode`: 4-bit op in, 12-bit one-hot and `legal` out, purely combinational.
- Pipeline registers, handshake logic and counters live in `alu_issue`.
- The existing `alu` is instantiated beside this block, not inside it.

## Test plan
- Add: op 0, src1=5, src2=7, tag=3, `rsp_ready`=1. Required: `alu_control`=0x800 one cycle later, then `rsp_valid` with result 12, tag 3, err 0.
- Sub wrap: op 1, src1=0, src2=1. Required: result 0xFFFF_FFFF_FFFF_FFFF.
- Backpressure: 4 back-to-back requests (tags 0–3) with `rsp_ready`=0.
  - Required while held: only tags 0 and 1 accepted, `req_ready` low, `alu_control` stable.
  - Then raise `rsp_ready`. Required: tags 0,1,2,3 returned in order, each exactly once.
- Illegal op 13, src1=src2=0xFF. Required: `alu_control`=0 in S1, response result 0 with err 1, `err_count`=1, `issue_count`=1.
- Reset mid-flight: with S1 and S2 full, pulse `reset` asynchronously between edges. Required: `rsp_valid`, `alu_control` and counters drop to 0 immediately, and no stale response appears after release.
- Throughput: 100 random legal ops with `rsp_ready`=1. Required: 100 responses within 102 cycles, results matching a reference model, `issue_count`=100.
